// File: rtl/spi_pkg.sv
// Shared SPI constants, register map, FSM state type and frame builder.
// Pure definitions; no timing or flow-control behaviour lives here.
package spi_pkg;

    localparam int SPI_FRAME_W = 16;
    localparam int SPI_ADDR_W  = 7;

    localparam logic [SPI_ADDR_W-1:0] en_reg_out_7_0  = 7'h00;
    localparam logic [SPI_ADDR_W-1:0] en_reg_out_15_8 = 7'h01;
    localparam logic [SPI_ADDR_W-1:0] en_reg_pwm_7_0  = 7'h02;
    localparam logic [SPI_ADDR_W-1:0] en_reg_pwm_15_8 = 7'h03;
    localparam logic [SPI_ADDR_W-1:0] pwm_duty_cycle  = 7'h04;

    localparam logic [SPI_ADDR_W-1:0] SPI_ADDR_MAX = 7'h04;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } spi_state_t;

    function automatic logic [SPI_FRAME_W-1:0] spi_frame(
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [7:0]            data
    );
        return {1'b1, addr, data};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: one-cycle o_tick every CLK_DIV cycles while i_en is high.
// Counter clears whenever disabled; no backpressure.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && w_last;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: one {1,addr,data} frame per accepted request, ncs low 33*CLK_DIV cycles.
// req_ready drops for the whole frame plus gap; SPI_CTRL_ADDR_CHECK_EN rejects addr > SPI_ADDR_MAX with err.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       done,
    output logic       err,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    spi_state_t             r_state;
    spi_state_t             w_next;
    logic [SPI_FRAME_W-1:0] r_shreg;
    logic [3:0]             r_bit;
    logic                   r_phase;
    logic                   r_done;
    logic                   r_err;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_tick;
    logic                   w_last_bit;

    assign w_accept = req_valid && req_ready;

`ifdef SPI_CTRL_ADDR_CHECK_EN
    assign w_reject = w_accept && (req_addr > SPI_ADDR_MAX);
`else
    assign w_reject = 1'b0;
`endif

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state != IDLE),
        .o_tick (w_tick)
    );

    // r_phase: in SHIFT 0 = sclk high, 1 = sclk low; in GAP it counts the two half-periods.
    assign w_last_bit = (r_state == SHIFT) && w_tick && r_phase && (r_bit == 4'd15);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_reject) w_next = SETUP;
            SETUP:   if (w_tick)                w_next = SHIFT;
            SHIFT:   if (w_last_bit)            w_next = GAP;
            GAP:     if (w_tick && r_phase)     w_next = IDLE;
            default:                            w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_last_bit;
            r_err   <= w_reject;
            case (r_state)
                IDLE: begin
                    if (w_accept && !w_reject) begin
                        r_shreg <= spi_frame(req_addr, req_data);
                        r_bit   <= '0;
                        r_phase <= 1'b0;
                    end
                end
                SETUP: begin
                    if (w_tick) r_phase <= 1'b0;
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            // bit 0 stays on copi through the trailing low phase as hold time
                            if (r_bit != 4'd15) r_shreg <= {r_shreg[SPI_FRAME_W-2:0], 1'b0};
                        end else begin
                            r_phase <= 1'b0;
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (w_tick) r_phase <= ~r_phase;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE) && !r_err;
    assign sclk      = (r_state == SHIFT) && !r_phase;
    assign ncs       = !((r_state == SETUP) || (r_state == SHIFT));
    assign copi      = !ncs && r_shreg[SPI_FRAME_W-1];
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: table of single writes plus back-to-back, mid-frame reset and out-of-map address.
// A behavioural SPI target samples copi on sclk rise and keeps only complete 16-bit frames.
module tb_spi_controller;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, done, err, sclk, ncs, copi;

    spi_controller #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .done      (done),
        .err       (err),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SPI target model
    logic [15:0] rx_sh = '0;
    int          rx_cnt = 0;
    logic [15:0] frames[$];

    always @(posedge sclk) if (!ncs) begin
        rx_sh = {rx_sh[14:0], copi};
        rx_cnt++;
    end
    always @(negedge ncs) rx_cnt = 0;
    always @(posedge ncs) if (rx_cnt == 16) frames.push_back(rx_sh);

    // Waveform monitor, sampled mid-cycle
    int low_cnt = 0, last_low = 0, high_cnt = 0, last_gap = 0;
    int ncs_falls = 0, done_cnt = 0, err_cnt = 0, done_bad = 0;
    logic prev_ncs = 1'b1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (!(ncs && !prev_ncs)) done_bad++;
        end
        if (err) err_cnt++;
        if (!ncs) low_cnt++;
        else if (low_cnt != 0) begin last_low = low_cnt; low_cnt = 0; end
        if (ncs) high_cnt++;
        else if (high_cnt != 0) begin last_gap = high_cnt; high_cnt = 0; ncs_falls++; end
        prev_ncs = ncs;
    end

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, output int ready_low);
        int i;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        i = 0;
        while (!req_ready && i < 2000) begin @(negedge clk); i++; end
        chk("accept_wait", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        ready_low = 0;
        @(negedge clk);
        while (!req_ready && ready_low < 2000) begin ready_low++; @(negedge clk); end
    endtask

    function automatic logic [15:0] frame_at(input int idx);
        return (frames.size() > idx) ? frames[idx] : 16'h0000;
    endfunction

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] frame;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rl, d0, f0, i;

        vecs[0] = '{7'h00, 8'hA5, 16'h80A5};
        vecs[1] = '{7'h00, 8'hFF, 16'h80FF};
        vecs[2] = '{7'h02, 8'hFF, 16'h82FF};
        vecs[3] = '{7'h04, 8'h80, 16'h8480};
        vecs[4] = '{7'h03, 8'h5A, 16'h835A};
        vecs[5] = '{7'h01, 8'h00, 16'h8100};

        #23;
        chk("rst_sclk",  sclk, 1'b0);
        chk("rst_ncs",   ncs, 1'b1);
        chk("rst_copi",  copi, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_done",  done, 1'b0);
        chk("rst_err",   err, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            frames.delete();
            d0 = done_cnt;
            do_write(vecs[k].addr, vecs[k].data, rl);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_nframes", k), frames.size(), 1);
            chk($sformatf("v%0d_frame", k), frame_at(0), vecs[k].frame);
            chk($sformatf("v%0d_ncs_low", k), last_low, 33 * D);
            chk($sformatf("v%0d_ready_low", k), rl, 35 * D);
            chk($sformatf("v%0d_done", k), done_cnt - d0, 1);
        end

        // back-to-back with req_valid held
        frames.delete();
        d0 = done_cnt;
        f0 = ncs_falls;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 7'h04; req_data = 8'h80;
        @(posedge clk);
        @(negedge clk);
        req_addr = 7'h02; req_data = 8'hFF;
        i = 0;
        while (!req_ready && i < 2000) begin @(negedge clk); i++; end
        chk("b2b_second_ready", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        i = 0;
        @(negedge clk);
        while (!req_ready && i < 2000) begin @(negedge clk); i++; end
        repeat (4) @(negedge clk);
        chk("b2b_nframes", frames.size(), 2);
        chk("b2b_frame0", frame_at(0), 16'h8480);
        chk("b2b_frame1", frame_at(1), 16'h82FF);
        chk("b2b_gap_ge", (last_gap >= 2 * D + 1), 1'b1);
        chk("b2b_done", done_cnt - d0, 2);
        chk("b2b_ncs_falls", ncs_falls - f0, 2);

        // reset in the middle of bit 7
        frames.delete();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 7'h01; req_data = 8'h3C;
        @(posedge clk);
        #1 req_valid = 1'b0;
        i = 0;
        while (rx_cnt != 9 && i < 5000) begin @(posedge clk); i++; end
        chk("mid_reach_bit7", rx_cnt, 9);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_ncs",   ncs, 1'b1);
        chk("mid_sclk",  sclk, 1'b0);
        chk("mid_copi",  copi, 1'b0);
        chk("mid_ready", req_ready, 1'b1);
        chk("mid_done",  done, 1'b0);
        chk("mid_nframes", frames.size(), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        do_write(7'h04, 8'h80, rl);
        repeat (2) @(negedge clk);
        chk("post_rst_frame", frame_at(0), 16'h8480);
        chk("post_rst_ready_low", rl, 35 * D);
        chk("post_rst_done", done_cnt - d0, 1);

        // out-of-map address
        frames.delete();
        f0 = ncs_falls;
        d0 = err_cnt;
        do_write(7'h10, 8'h55, rl);
        repeat (2) @(negedge clk);
`ifdef SPI_CTRL_ADDR_CHECK_EN
        chk("badaddr_ready_low", rl, 1);
        chk("badaddr_err", err_cnt - d0, 1);
        chk("badaddr_ncs_quiet", ncs_falls - f0, 0);
        chk("badaddr_nframes", frames.size(), 0);
`else
        chk("addr10_ready_low", rl, 35 * D);
        chk("addr10_frame", frame_at(0), 16'h9055);
        chk("addr10_ncs_low", last_low, 33 * D);
        chk("addr10_err_total", err_cnt, 0);
`endif

        chk("done_alignment", done_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
